// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and command bytes for the program loader
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        LEN_LO,
        LEN_HI,
        PAY_LO,
        PAY_HI,
        DONE
    } state_t;

    localparam logic [7:0] CMD_INST = 8'hA1;
    localparam logic [7:0] CMD_DATA = 8'hA2;
    localparam logic [7:0] CMD_END  = 8'hAF;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream loader filling instruction ROM and data memory
module prog_loader
    import loader_pkg::*;
#(
    parameter int IW  = 9,
    parameter int IAW = 10,
    parameter int DW  = 8,
    parameter int DAW = 8
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [7:0]     in_data,
    output logic           in_ready,
    output logic           inst_wr_en,
    output logic [IAW-1:0] inst_addr,
    output logic [IW-1:0]  inst_wr_data,
    output logic           data_wr_en,
    output logic [DAW-1:0] data_addr,
    output logic [DW-1:0]  data_wr_data,
    output logic           done,
    output logic           cpu_start,
    output logic           err
);

    state_t         state_q;
    logic           ready_q;
    logic           tgt_inst_q;
    logic [15:0]    ptr_q;
    logic [15:0]    cnt_q;
    logic [7:0]     lo_q;
    logic           inst_we_q;
    logic [IAW-1:0] inst_addr_q;
    logic [IW-1:0]  inst_data_q;
    logic           data_we_q;
    logic [DAW-1:0] data_addr_q;
    logic [DW-1:0]  data_data_q;
    logic           done_q;
    logic           start_q;
    logic           err_q;

    logic xfer;
    assign xfer = in_valid && ready_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            tgt_inst_q  <= 1'b0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            lo_q        <= '0;
            inst_we_q   <= 1'b0;
            inst_addr_q <= '0;
            inst_data_q <= '0;
            data_we_q   <= 1'b0;
            data_addr_q <= '0;
            data_data_q <= '0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Strobes and the start pulse live for a single cycle unless re-armed below.
            inst_we_q <= 1'b0;
            data_we_q <= 1'b0;
            start_q   <= 1'b0;
            ready_q   <= (state_q != DONE);
            if (xfer) begin
                case (state_q)
                    IDLE: begin
                        if (in_data == CMD_INST) begin
                            tgt_inst_q <= 1'b1;
                            state_q    <= ADDR_LO;
                        end else if (in_data == CMD_DATA) begin
                            tgt_inst_q <= 1'b0;
                            state_q    <= ADDR_LO;
                        end else if (in_data == CMD_END) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            start_q <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    ADDR_LO: begin
                        ptr_q[7:0] <= in_data;
                        state_q    <= ADDR_HI;
                    end
                    ADDR_HI: begin
                        ptr_q[15:8] <= in_data;
                        state_q     <= LEN_LO;
                    end
                    LEN_LO: begin
                        cnt_q[7:0] <= in_data;
                        state_q    <= LEN_HI;
                    end
                    LEN_HI: begin
                        cnt_q[15:8] <= in_data;
                        state_q     <= ({in_data, cnt_q[7:0]} == 16'd0) ? IDLE : PAY_LO;
                    end
                    PAY_LO: begin
                        if (tgt_inst_q) begin
                            lo_q    <= in_data;
                            state_q <= PAY_HI;
                        end else begin
                            data_we_q   <= 1'b1;
                            data_addr_q <= ptr_q[DAW-1:0];
                            data_data_q <= DW'(in_data);
                            ptr_q       <= ptr_q + 16'd1;
                            cnt_q       <= cnt_q - 16'd1;
                            state_q     <= (cnt_q == 16'd1) ? IDLE : PAY_LO;
                        end
                    end
                    PAY_HI: begin
                        inst_we_q   <= 1'b1;
                        inst_addr_q <= ptr_q[IAW-1:0];
                        inst_data_q <= IW'({in_data[0], lo_q});
                        ptr_q       <= ptr_q + 16'd1;
                        cnt_q       <= cnt_q - 16'd1;
                        state_q     <= (cnt_q == 16'd1) ? IDLE : PAY_LO;
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign in_ready     = ready_q;
    assign inst_wr_en   = inst_we_q;
    assign inst_addr    = inst_addr_q;
    assign inst_wr_data = inst_data_q;
    assign data_wr_en   = data_we_q;
    assign data_addr    = data_addr_q;
    assign data_wr_data = data_data_q;
    assign done         = done_q;
    assign cpu_start    = start_q;
    assign err          = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed and randomized bench for prog_loader
module tb_prog_loader;

    localparam int IW  = 9;
    localparam int IAW = 10;
    localparam int DW  = 8;
    localparam int DAW = 8;

    logic           CLK = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic [7:0]     in_data = 8'h00;
    logic           in_ready;
    logic           inst_wr_en;
    logic [IAW-1:0] inst_addr;
    logic [IW-1:0]  inst_wr_data;
    logic           data_wr_en;
    logic [DAW-1:0] data_addr;
    logic [DW-1:0]  data_wr_data;
    logic           done;
    logic           cpu_start;
    logic           err;

    prog_loader #(.IW(IW), .IAW(IAW), .DW(DW), .DAW(DAW)) dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .inst_wr_en(inst_wr_en), .inst_addr(inst_addr),
        .inst_wr_data(inst_wr_data), .data_wr_en(data_wr_en), .data_addr(data_addr),
        .data_wr_data(data_wr_data), .done(done), .cpu_start(cpu_start), .err(err)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int xfers = 0;
    int starts = 0;
    int both = 0;
    int cyc = 0;
    bit err_exp = 1'b0;
    bit done_exp = 1'b0;
    int unsigned got_i[$];
    int unsigned got_d[$];
    int unsigned exp_i[$];
    int unsigned exp_d[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (inst_wr_en) got_i.push_back((32'(inst_addr) << 16) | 32'(inst_wr_data));
        if (data_wr_en) got_d.push_back((32'(data_addr) << 16) | 32'(data_wr_data));
        if (!reset && in_valid && in_ready) xfers++;
        if (cpu_start) starts++;
        if (inst_wr_en && data_wr_en) both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packet-level reference: walks the byte list as whole commands.
    task automatic model(input logic [7:0] s[$]);
        int i = 0;
        int a, n;
        bit is_inst;
        while (i < s.size() && !done_exp) begin
            if (s[i] == 8'hA1 || s[i] == 8'hA2) begin
                is_inst = (s[i] == 8'hA1);
                a = int'(s[i+1]) + 256 * int'(s[i+2]);
                n = int'(s[i+3]) + 256 * int'(s[i+4]);
                i += 5;
                for (int w = 0; w < n; w++) begin
                    if (is_inst) begin
                        exp_i.push_back(((a + w) % 1024) * 65536 + int'(s[i]) + 256 * (int'(s[i+1]) % 2));
                        i += 2;
                    end else begin
                        exp_d.push_back(((a + w) % 256) * 65536 + int'(s[i]));
                        i += 1;
                    end
                end
            end else if (s[i] == 8'hAF) begin
                done_exp = 1'b1;
                i++;
            end else begin
                err_exp = 1'b1;
                i++;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int k = 0;
        if (gaps) begin
            int g = $urandom_range(0, 2);
            repeat (g) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge CLK); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && k < 50) begin
            @(posedge CLK); #1;
            k++;
        end
        check("send_timeout", 32'(k < 50), 32'd1);
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_inst_we", 32'(inst_wr_en), 32'd0);
        check("rst_data_we", 32'(data_wr_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_start", 32'(cpu_start), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_iaddr", 32'(inst_addr), 32'd0);
        check("rst_daddr", 32'(data_addr), 32'd0);
        check("rst_idata", 32'(inst_wr_data), 32'd0);
        check("rst_ddata", 32'(data_wr_data), 32'd0);
        reset = 1'b0;
        err_exp  = 1'b0;
        done_exp = 1'b0;
        starts   = 0;
        @(posedge CLK); #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_stream(input logic [7:0] s[$], input bit gaps, input string tag);
        int x0, c0, c1, m;
        got_i.delete(); got_d.delete(); exp_i.delete(); exp_d.delete();
        model(s);
        x0 = xfers;
        c0 = cyc;
        foreach (s[k]) send_byte(s[k], gaps);
        c1 = cyc;
        in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        if (!gaps) check({tag, "_cycles"}, 32'(c1 - c0), 32'(s.size()));
        check({tag, "_xfers"}, 32'(xfers - x0), 32'(s.size()));
        check({tag, "_ninst"}, 32'(got_i.size()), 32'(exp_i.size()));
        check({tag, "_ndata"}, 32'(got_d.size()), 32'(exp_d.size()));
        m = (got_i.size() < exp_i.size()) ? got_i.size() : exp_i.size();
        for (int i = 0; i < m; i++) check({tag, "_inst"}, got_i[i], exp_i[i]);
        m = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < m; i++) check({tag, "_data"}, got_d[i], exp_d[i]);
        check({tag, "_err"}, 32'(err), 32'(err_exp));
        check({tag, "_done"}, 32'(done), 32'(done_exp));
        check({tag, "_both"}, 32'(both), 32'd0);
    endtask

    initial begin
        logic [7:0] s[$];
        int x0;

        do_reset();

        s = '{8'hA1, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h01, 8'h56, 8'h00};
        run_stream(s, 1'b0, "inst2");
        check("inst2_exp0", exp_i.size() > 0 ? exp_i[0] : 0, 32'h0010_0134);

        s = '{8'hA2, 8'hFF, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
        run_stream(s, 1'b0, "wrap");

        s = '{8'h7E};
        run_stream(s, 1'b0, "bad");
        check("bad_err_set", 32'(err), 32'd1);
        s = '{8'hA2, 8'h00, 8'h00, 8'h01, 8'h00, 8'h99};
        run_stream(s, 1'b0, "after_bad");

        do_reset();
        got_i.delete();
        s = '{8'hA1, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAB};
        foreach (s[k]) send_byte(s[k], 1'b0);
        in_valid = 1'b0;
        do_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("partial_no_write", 32'(got_i.size()), 32'd0);
        s = '{8'hA1, 8'h3F, 8'h02, 8'h01, 8'h00, 8'hCD, 8'hFF};
        run_stream(s, 1'b0, "fresh");

        s = '{8'hA1, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h01, 8'h56, 8'h00};
        run_stream(s, 1'b1, "gaps");

        for (int it = 0; it < 8; it++) begin
            int np;
            s.delete();
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
                int n;
                logic [15:0] a;
                if ($urandom_range(0, 4) == 0) s.push_back(8'($urandom_range(0, 8'h9F)));
                case ($urandom_range(0, 2))
                    0: a = 16'hFFFE;
                    1: a = 16'h03FE;
                    default: a = 16'($urandom);
                endcase
                n = $urandom_range(0, 4);
                if ($urandom_range(0, 1) == 1) begin
                    s.push_back(8'hA1);
                    s.push_back(a[7:0]); s.push_back(a[15:8]);
                    s.push_back(8'(n)); s.push_back(8'h00);
                    for (int w = 0; w < 2 * n; w++) s.push_back(8'($urandom));
                end else begin
                    s.push_back(8'hA2);
                    s.push_back(a[7:0]); s.push_back(a[15:8]);
                    s.push_back(8'(n)); s.push_back(8'h00);
                    for (int w = 0; w < n; w++) s.push_back(8'($urandom));
                end
            end
            run_stream(s, 1'($urandom_range(0, 1)), "rand");
        end

        do_reset();
        s = '{8'hA2, 8'h05, 8'h00, 8'h00, 8'h00, 8'hAF};
        run_stream(s, 1'b0, "end");
        check("end_start_pulses", 32'(starts), 32'd1);
        check("end_ready", 32'(in_ready), 32'd0);
        x0 = xfers;
        in_valid = 1'b1;
        in_data  = 8'hA2;
        repeat (5) @(posedge CLK);
        #1;
        in_valid = 1'b0;
        check("end_no_accept", 32'(xfers - x0), 32'd0);
        check("end_done_sticky", 32'(done), 32'd1);
        check("end_start_once", 32'(starts), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
